// File: rtl/input_conditioner.sv
// input_conditioner: synchronises, debounces and conflict-resolves the raw
// board switches and buttons ahead of the game-logic state machine. Buttons
// additionally produce a registered one-cycle pulse when a press is accepted.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic vga_clock,
  input  logic reset,
  input  logic raw_left_switch,
  input  logic raw_right_switch,
  input  logic raw_jump_button,
  input  logic raw_start_button,
  output logic left_switch,
  output logic right_switch,
  output logic jump_button,
  output logic start_button,
  output logic jump_press,
  output logic start_press
);

  // Bit order for every per-input vector: 0 left, 1 right, 2 jump, 3 start.
  localparam int NUM_IN = 4;
  // Idle levels: switches off (0), buttons released (1, active-low).
  localparam logic [NUM_IN-1:0] IDLE     = 4'b1100;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_t;

  logic [NUM_IN-1:0]                   raw;
  logic [SYNC_STAGES-1:0][NUM_IN-1:0]  sync_q;
  logic [NUM_IN-1:0]                   sync;

  db_state_t                           state_q   [NUM_IN];
  db_state_t                           state_nxt [NUM_IN];
  logic [CNT_W-1:0]                    cnt_q     [NUM_IN];
  logic [CNT_W-1:0]                    cnt_nxt   [NUM_IN];
  logic [NUM_IN-1:0]                   db_q;
  logic [NUM_IN-1:0]                   db_nxt;

  logic [1:0]                          btn_db;
  logic [1:0]                          btn_db_prev_q;
  logic [1:0]                          armed_q;
  logic [1:0]                          press_q;

  assign raw  = {raw_start_button, raw_jump_button, raw_right_switch, raw_left_switch};
  assign sync = sync_q[SYNC_STAGES-1];

  // ---- stage 1: synchroniser chain, resets to idle levels ----
  // Shift each raw input through SYNC_STAGES flops to tame metastability.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{IDLE}};
    end else begin
      sync_q[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // ---- stage 2: per-input debounce FSM ----
  // Register the debounce state, counter and accepted level of every input.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_IN; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      db_q <= IDLE;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        state_q[i] <= state_nxt[i];
        cnt_q[i]   <= cnt_nxt[i];
      end
      db_q <= db_nxt;
    end
  end

  // Accept a change only after DEBOUNCE_CYCLES consecutive differing samples;
  // any sample matching the current level abandons the pending change.
  always_comb begin
    db_nxt = db_q;
    for (int i = 0; i < NUM_IN; i++) begin
      state_nxt[i] = state_q[i];
      cnt_nxt[i]   = cnt_q[i];
      case (state_q[i])
        STABLE: begin
          cnt_nxt[i] = '0;
          if (sync[i] != db_q[i]) begin
            // A single-cycle qualification accepts without visiting PENDING.
            if (DEBOUNCE_CYCLES == 1) begin
              db_nxt[i] = sync[i];
            end else begin
              state_nxt[i] = PENDING;
              cnt_nxt[i]   = CNT_ONE;
            end
          end
        end
        PENDING: begin
          if (sync[i] == db_q[i]) begin
            state_nxt[i] = STABLE;
            cnt_nxt[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            db_nxt[i]    = sync[i];
            state_nxt[i] = STABLE;
            cnt_nxt[i]   = '0;
          end else begin
            cnt_nxt[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_nxt[i] = STABLE;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // ---- stage 3: button press edge detection ----
  assign btn_db = db_q[3:2];

  // Pulse one cycle after an armed button's accepted level falls 1->0.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      btn_db_prev_q <= 2'b11;
      armed_q       <= 2'b00;
      press_q       <= 2'b00;
    end else begin
      btn_db_prev_q <= btn_db;
      armed_q       <= armed_q | btn_db;
      press_q       <= armed_q & btn_db_prev_q & ~btn_db;
    end
  end

  // Both switches on cancels out rather than favouring either direction.
  assign left_switch  = db_q[0] & ~db_q[1];
  assign right_switch = db_q[1] & ~db_q[0];
  assign jump_button  = db_q[2];
  assign start_button = db_q[3];
  assign jump_press   = press_q[0];
  assign start_press  = press_q[1];

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed bench for input_conditioner with
// SYNC_STAGES=2, DEBOUNCE_CYCLES=4 (clean edge to level change = 6 cycles).
module tb_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LAT  = SYNC + DEB;
  localparam logic [5:0] IDLE_OUTS = 6'b001100;

  logic vga_clock = 1'b0;
  logic reset;
  logic raw_left_switch, raw_right_switch, raw_jump_button, raw_start_button;
  logic left_switch, right_switch, jump_button, start_button;
  logic jump_press, start_press;
  logic [5:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 vga_clock = ~vga_clock;

  assign outs = {left_switch, right_switch, jump_button, start_button, jump_press, start_press};

  input_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .vga_clock       (vga_clock),
    .reset           (reset),
    .raw_left_switch (raw_left_switch),
    .raw_right_switch(raw_right_switch),
    .raw_jump_button (raw_jump_button),
    .raw_start_button(raw_start_button),
    .left_switch     (left_switch),
    .right_switch    (right_switch),
    .jump_button     (jump_button),
    .start_button    (start_button),
    .jump_press      (jump_press),
    .start_press     (start_press)
  );

  task automatic step();
    @(posedge vga_clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    raw_left_switch = 1'b0; raw_right_switch = 1'b0;
    raw_jump_button = 1'b1; raw_start_button = 1'b1;
    #1;
    n_checks++;
    if (outs !== IDLE_OUTS) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", outs, IDLE_OUTS);
    end
    step(); step();
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_checks++;
      if (outs !== IDLE_OUTS) begin
        n_fail++;
        $display("FAIL idle_hold cycle %0d: got %b expected %b", k, outs, IDLE_OUTS);
      end
    end
  endtask

  task automatic test_jump_press();
    logic exp_lvl, exp_p;
    raw_jump_button = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_lvl = (k >= LAT) ? 1'b0 : 1'b1;
      exp_p   = (k == LAT + 1);
      n_checks++;
      if (jump_button !== exp_lvl) begin
        n_fail++;
        $display("FAIL jump_level T+%0d: got %b expected %b", k, jump_button, exp_lvl);
      end
      n_checks++;
      if (jump_press !== exp_p) begin
        n_fail++;
        $display("FAIL jump_press T+%0d: got %b expected %b", k, jump_press, exp_p);
      end
    end
    raw_jump_button = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++;
      if (jump_press !== 1'b0) begin
        n_fail++;
        $display("FAIL jump_release_pulse T+%0d: got %b expected 0", k, jump_press);
      end
    end
    n_checks++;
    if (jump_button !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_released_level: got %b expected 1", jump_button);
    end
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 5; r++) begin
      for (int ph = 0; ph < 2; ph++) begin
        raw_start_button = (ph == 0) ? 1'b0 : 1'b1;
        for (int k = 0; k < 3; k++) begin
          step();
          n_checks++;
          if (start_button !== 1'b1 || start_press !== 1'b0) begin
            n_fail++;
            $display("FAIL start_bounce r%0d ph%0d: got level %b pulse %b expected 1 0",
                     r, ph, start_button, start_press);
          end
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if (start_button !== 1'b1 || start_press !== 1'b0) begin
        n_fail++;
        $display("FAIL start_bounce_tail: got level %b pulse %b expected 1 0",
                 start_button, start_press);
      end
    end
  endtask

  task automatic test_conflict();
    logic exp_l, exp_r;
    raw_left_switch = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_l = (k >= LAT);
      n_checks++;
      if (left_switch !== exp_l || right_switch !== 1'b0) begin
        n_fail++;
        $display("FAIL left_on T+%0d: got L=%b R=%b expected L=%b R=0", k, left_switch, right_switch, exp_l);
      end
    end
    raw_right_switch = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_l = (k < LAT);
      n_checks++;
      if (left_switch !== exp_l || right_switch !== 1'b0) begin
        n_fail++;
        $display("FAIL both_on T+%0d: got L=%b R=%b expected L=%b R=0", k, left_switch, right_switch, exp_l);
      end
    end
    raw_left_switch = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_r = (k >= LAT);
      n_checks++;
      if (right_switch !== exp_r || left_switch !== 1'b0) begin
        n_fail++;
        $display("FAIL right_only T+%0d: got L=%b R=%b expected L=0 R=%b", k, left_switch, right_switch, exp_r);
      end
    end
    raw_right_switch = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_r = (k < LAT);
      n_checks++;
      if (right_switch !== exp_r || left_switch !== 1'b0) begin
        n_fail++;
        $display("FAIL right_off T+%0d: got L=%b R=%b expected L=0 R=%b", k, left_switch, right_switch, exp_r);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_lvl, exp_p;
    raw_jump_button = 1'b0;
    // Two sync edges plus two debounce edges leaves the counter at 2.
    for (int k = 0; k < 4; k++) step();
    n_checks++;
    if (jump_button !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pending: got %b expected 1", jump_button);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (outs !== IDLE_OUTS) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got %b expected %b", outs, IDLE_OUTS);
    end
    step();
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_lvl = (k >= LAT) ? 1'b0 : 1'b1;
      exp_p   = (k == LAT + 1);
      n_checks++;
      if (jump_button !== exp_lvl || jump_press !== exp_p) begin
        n_fail++;
        $display("FAIL reset_mid_requal R+%0d: got level %b pulse %b expected %b %b",
                 k, jump_button, jump_press, exp_lvl, exp_p);
      end
    end
    raw_jump_button = 1'b1;
    for (int k = 0; k < 10; k++) step();
    n_checks++;
    if (outs !== IDLE_OUTS) begin
      n_fail++;
      $display("FAIL reset_mid_recover: got %b expected %b", outs, IDLE_OUTS);
    end
  endtask

  task automatic test_reset_pulse();
    raw_jump_button = 1'b0;
    for (int k = 0; k < LAT + 1; k++) step();
    n_checks++;
    if (jump_press !== 1'b1) begin
      n_fail++;
      $display("FAIL pulse_before_reset: got %b expected 1", jump_press);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (jump_press !== 1'b0 || jump_button !== 1'b1) begin
      n_fail++;
      $display("FAIL pulse_cleared_by_reset: got pulse %b level %b expected 0 1", jump_press, jump_button);
    end
    step();
    reset = 1'b0;
    raw_jump_button = 1'b1;
    for (int k = 0; k < 10; k++) step();
    n_checks++;
    if (outs !== IDLE_OUTS) begin
      n_fail++;
      $display("FAIL reset_pulse_recover: got %b expected %b", outs, IDLE_OUTS);
    end
  endtask

  task automatic test_simultaneous();
    logic exp_lvl, exp_p;
    raw_jump_button  = 1'b0;
    raw_start_button = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_lvl = (k >= LAT) ? 1'b0 : 1'b1;
      exp_p   = (k == LAT + 1);
      n_checks++;
      if (jump_button !== exp_lvl || start_button !== exp_lvl) begin
        n_fail++;
        $display("FAIL simul_levels T+%0d: got J=%b S=%b expected %b", k, jump_button, start_button, exp_lvl);
      end
      n_checks++;
      if (jump_press !== exp_p || start_press !== exp_p) begin
        n_fail++;
        $display("FAIL simul_pulses T+%0d: got J=%b S=%b expected %b", k, jump_press, start_press, exp_p);
      end
    end
    raw_jump_button  = 1'b1;
    raw_start_button = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++;
      if (jump_press !== 1'b0 || start_press !== 1'b0) begin
        n_fail++;
        $display("FAIL simul_release T+%0d: got J=%b S=%b expected 0 0", k, jump_press, start_press);
      end
    end
    n_checks++;
    if (outs !== IDLE_OUTS) begin
      n_fail++;
      $display("FAIL simul_final: got %b expected %b", outs, IDLE_OUTS);
    end
  endtask

  initial begin
    test_reset();
    test_jump_press();
    test_bounce();
    test_conflict();
    test_reset_mid();
    test_reset_pulse();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Sits directly upstream of the game-logic state machine.
- Takes raw board inputs: two slide switches and two active-low push buttons.
- Synchronises each input to vga_clock and debounces it with a per-input counter FSM.
- Resolves left/right conflicts, and produces clean active-low button levels plus single-cycle press pulses for the game logic and level modules.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops per input; minimum 2.
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required to accept a change (10 ms at 25 MHz); minimum 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width.

Ports:
- vga_clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- raw_left_switch  input  1  slide switch, active-high, asynchronous.
- raw_right_switch  input  1  slide switch, active-high, asynchronous.
- raw_jump_button  input  1  push button, active-low, asynchronous.
- raw_start_button  input  1  push button, active-low, asynchronous.
- left_switch  output  1  debounced, conflict-resolved left request, active-high.
- right_switch  output  1  debounced, conflict-resolved right request, active-high.
- jump_button  output  1  debounced jump level, active-low.
- start_button  output  1  debounced start level, active-low.
- jump_press  output  1  one-cycle pulse on accepted jump press.
- start_press  output  1  one-cycle pulse on accepted start press.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All synchroniser flops and debounced states go to the idle value: switches 0, buttons 1.
  - All counters 0; arm flags 0.
  - Outputs: left_switch=0, right_switch=0, jump_button=1, start_button=1, jump_press=0, start_press=0.
- Synchroniser: SYNC_STAGES-flop chain per input. sync = last flop.
- Debounce FSM per input, states STABLE and PENDING. Every input has its own counter cnt and its own debounced state db.
  - STABLE: if sync==db, stay and keep cnt=0. If sync!=db, go to PENDING with cnt=1.
  - PENDING:
    - sync==db (bounce back): cnt=0, return to STABLE; db unchanged.
    - sync!=db and cnt==DEBOUNCE_CYCLES-1: db<=sync, cnt<=0, go to STABLE.
    - Otherwise cnt<=cnt+1.
  - DEBOUNCE_CYCLES=1: a difference in STABLE updates db immediately, with no PENDING visit.
  - Result: a change is accepted on its DEBOUNCE_CYCLES-th consecutive differing sampled cycle.
  - Latency from a clean raw edge to output change is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
  - Any bounce shorter than DEBOUNCE_CYCLES produces no output change.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Conflict resolution (combinational from the registered db values):
  - left_switch = db_left & ~db_right.
  - right_switch = db_right & ~db_left.
  - Both switches on gives both outputs 0 (no motion).
- Button levels: jump_button = db_jump; start_button = db_start (active-low preserved).
- Arming:
  - A button's arm flag sets on the first cycle its db is 1 (released) after reset release.
  - Because reset forces db=1, the flag sets on the first clock after reset release.
  - A button physically held through reset is accepted as pressed (db 1→0) after debounce; the flag is already set, so this produces one press pulse.
  - Arming therefore only blocks pulses in the cycle reset releases.
- Press pulse:
  - jump_press=1 for exactly one cycle, the cycle after db_jump transitions 1→0 while armed. Registered; one extra cycle of latency versus jump_button.
  - start_press behaves the same way.
  - Release (0→1) never pulses.
  - Holding a button produces one pulse only; no auto-repeat.
- Simultaneous events: inputs are fully independent; both buttons accepted in the same cycle give both pulses in the same cycle.
- Reset mid-operation:
  - Pending counts are discarded and any in-flight pulse is cleared immediately (asynchronous).
  - After release, a still-held button must complete a full DEBOUNCE_CYCLES qualification again.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4):
- Reset, then hold all raw inputs idle for 20 cycles → outputs stay 0,0,1,1,0,0 and no pulses.
- raw_jump_button 1→0 at cycle T, held → jump_button=0 at T+6; jump_press=1 only at T+7; no further pulses while held.
- raw_start_button toggles low for 3 cycles then high, repeated 5 times (bounce) → start_button stays 1 and start_press never asserts.
- raw_left_switch=1 stable, then raw_right_switch=1 → left_switch=1 from T+6; both outputs 0 once right is accepted; dropping left gives right_switch=1 after 6 cycles.
- Assert reset for 1 cycle while jump is held and PENDING with cnt=2 → outputs go to idle values immediately; after release, jump_button=0 only after 6 more held cycles, followed by one jump_press.
- Press jump and start within the same cycle → both levels fall in the same cycle; jump_press and start_press assert together for one cycle.
